// File: rtl/wb_write_arbiter.sv
// ============================================================================
// Module : wb_write_arbiter
// Brief  : Shares the register-file write port between write-back and a
//          one-entry auxiliary-result buffer, with starvation-driven stall.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_write_en_i,
    input  logic [2:0]  wb_write_dest_i,
    input  logic [15:0] wb_write_data_i,
    input  logic        aux_valid_i,
    input  logic [2:0]  aux_dest_i,
    input  logic [15:0] aux_data_i,
    output logic        aux_ready_o,
    output logic        rf_write_en_o,
    output logic [2:0]  rf_write_dest_o,
    output logic [15:0] rf_write_data_o,
    output logic        stall_req_o,
    output logic        aux_pending_o,
    output logic [2:0]  aux_pending_dest_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [2:0]  buf_dest_q, buf_dest_d;
    logic [15:0] buf_data_q, buf_data_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    logic full;
    logic accept;
    logic commit;

    assign full   = (state_q != IDLE);
    assign accept = aux_valid_i && (state_q == IDLE);
    // Buffer only drains in a cycle the write-back stage leaves the port idle.
    assign commit = full && !wb_write_en_i;

    assign aux_ready_o        = (state_q == IDLE);
    assign stall_req_o        = (state_q == FORCE);
    assign aux_pending_o      = full;
    assign aux_pending_dest_o = full ? buf_dest_q : 3'd0;

    always_comb begin
        rf_write_en_o   = 1'b0;
        rf_write_dest_o = 3'd0;
        rf_write_data_o = 16'd0;
        if (wb_write_en_i) begin
            rf_write_en_o   = 1'b1;
            rf_write_dest_o = wb_write_dest_i;
            rf_write_data_o = wb_write_data_i;
        end else if (full) begin
            rf_write_en_o   = 1'b1;
            rf_write_dest_o = buf_dest_q;
            rf_write_data_o = buf_data_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_dest_d   = buf_dest_q;
        buf_data_d   = buf_data_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_dest_d   = aux_dest_i;
                    buf_data_d   = aux_data_i;
                    starve_cnt_d = 4'd0;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (commit) begin
                    starve_cnt_d = 4'd0;
                    state_d      = IDLE;
                end else begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                    if (starve_cnt_q + 4'd1 == LIMIT) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                // Lost cycles here are not counted; the stall is already up.
                if (commit) begin
                    starve_cnt_d = 4'd0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                starve_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            buf_dest_q   <= 3'd0;
            buf_data_q   <= 16'd0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            buf_dest_q   <= buf_dest_d;
            buf_data_q   <= buf_data_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

`default_nettype wire
